// File: rtl/prio_encoder_rr_pkg.sv
// Shared definitions for the registered priority encoder: mode encodings and a
// width helper usable in parameter expressions.
package prio_encoder_rr_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/prio_encoder_rr_if.sv
// Request/result bundle between the request source, the encoder and its consumer.
interface prio_encoder_rr_if
  import prio_encoder_rr_pkg::*;
#(
  parameter int N = 4
);
  localparam int W = clog2(N);

  logic [N-1:0] req;
  logic         rr_mode;
  logic         out_ready;
  logic [W-1:0] y;
  logic         out_valid;
  logic         multi;
  logic [W-1:0] ptr;

  modport master (
    output req, rr_mode, out_ready,
    input  y, out_valid, multi, ptr
  );

  modport slave (
    input  req, rr_mode, out_ready,
    output y, out_valid, multi, ptr
  );

endinterface

// File: rtl/prio_encoder_rr_scan.sv
// Combinational winner search: highest set index in fixed mode, first set index
// at or after start (wrapping at N-1) in round-robin mode.
module prio_encoder_rr_scan
  import prio_encoder_rr_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         multi
);

  logic [N-1:0] rot;
  logic [W-1:0] hi;
  int           off;
  int           sum;
  int           cnt;

  always_comb begin
    // Rotating the doubled vector puts req[start] at bit 0; start is always < N.
    rot = N'({req, req} >> start);
    off = 0;
    hi  = '0;
    cnt = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    for (int k = 0; k < N; k++) begin
      if (req[k]) begin
        hi  = W'(k);
        cnt = cnt + 1;
      end
    end
    sum = int'(start) + off;
    if (sum >= N) sum = sum - N;
    idx   = (mode == MODE_RR) ? W'(sum) : hi;
    any   = |req;
    multi = (cnt > 1);
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with valid/ready output and a
// round-robin start pointer that advances when an RR-mode encoding is accepted.
module prio_encoder_rr
  import prio_encoder_rr_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  prio_encoder_rr_if.slave  bus
);

  logic [W-1:0] y_q, y_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         valid_q, valid_d;
  logic         multi_q, multi_d;
  logic         tag_q, tag_d;

  logic [W-1:0] scan_idx;
  logic         scan_any;
  logic         scan_multi;
  logic         cap;
  logic         acc;

  // The scan always starts from the registered pointer, so a capture on the
  // same edge as an accept still uses the pre-update pointer.
  prio_encoder_rr_scan #(.N(N), .W(W)) u_scan (
    .req   (bus.req),
    .start (ptr_q),
    .mode  (bus.rr_mode),
    .idx   (scan_idx),
    .any   (scan_any),
    .multi (scan_multi)
  );

  always_comb begin
    cap     = !valid_q || bus.out_ready;
    acc     = valid_q && bus.out_ready;
    y_d     = y_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    multi_d = multi_q;
    tag_d   = tag_q;
    if (acc && (tag_q == MODE_RR)) begin
      ptr_d = (y_q == W'(N - 1)) ? '0 : y_q + W'(1);
    end
    if (cap) begin
      if (scan_any) begin
        valid_d = 1'b1;
        y_d     = scan_idx;
        multi_d = scan_multi;
        tag_d   = bus.rr_mode;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      tag_q   <= MODE_FIXED;
    end else begin
      y_q     <= y_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
      tag_q   <= tag_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.ptr       = ptr_q;
  assign bus.out_valid = valid_q;
  assign bus.multi     = multi_q;

endmodule
